// File: rtl/simd_window_sequencer.sv
// Frame sequencer for the bilinear downscaler: walks the source image in
// 4-lane chunks, requests a 5-pixel window from rows y and y+1, strobes the
// SIMD register-file load, launches the SIMD core and waits for it to finish.
//
// Handshakes: o_rd_req is held with stable addresses until i_rd_ack is seen
// high on a rising edge; i_rd_valid is consumed only in WAIT_MEM, where it
// raises o_load_enable combinationally in the same cycle; i_simd_done is
// consumed only in COMPUTE. i_abort overrides every other input.
module simd_window_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [DIM_W-1:0]  i_img_width,
  input  logic [DIM_W-1:0]  i_img_height,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr0,
  output logic [ADDR_W-1:0] o_rd_addr1,
  input  logic              i_rd_ack,
  input  logic              i_rd_valid,
  output logic              o_load_enable,
  output logic              o_simd_start,
  input  logic              i_simd_done,
  output logic [DIM_W-1:0]  o_x,
  output logic [DIM_W-1:0]  o_y,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_COMPUTE  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        r_state;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [DIM_W-1:0]  r_x;
  logic [DIM_W-1:0]  r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_err;

  logic              w_size_ok;
  logic              w_more_x;
  logic              w_more_y;
  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_addr1;

  // One extra bit keeps x+8 / y+2 from wrapping near the top of the range.
  assign w_size_ok = (i_img_width >= DIM_W'(5)) && (i_img_height >= DIM_W'(2));
  assign w_more_x  = ({1'b0, r_x} + (DIM_W+1)'(8)) <= ({1'b0, r_width} - (DIM_W+1)'(1));
  assign w_more_y  = ({1'b0, r_y} + (DIM_W+1)'(2)) <= ({1'b0, r_height} - (DIM_W+1)'(1));

  // Row base is accumulated by W per row pair, so no multiplier is needed;
  // both sums wrap modulo 2^ADDR_W.
  assign w_addr0 = r_row_base + ADDR_W'(r_x);
  assign w_addr1 = w_addr0 + ADDR_W'(r_width);

  // Frame/chunk FSM with abort override and coordinate bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_height   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_abort) begin
        r_state    <= S_IDLE;
        r_x        <= '0;
        r_y        <= '0;
        r_row_base <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (w_size_ok) begin
                r_width    <= i_img_width;
                r_height   <= i_img_height;
                r_row_base <= i_base_addr;
                r_x        <= '0;
                r_y        <= '0;
                r_state    <= S_REQ;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (i_rd_ack) r_state <= S_WAIT_MEM;
          end
          S_WAIT_MEM: begin
            if (i_rd_valid) r_state <= S_LOAD;
          end
          S_LOAD: begin
            r_state <= S_COMPUTE;
          end
          S_COMPUTE: begin
            if (i_simd_done) begin
              if (w_more_x) begin
                r_x     <= r_x + DIM_W'(4);
                r_state <= S_REQ;
              end else if (w_more_y) begin
                r_x        <= '0;
                r_y        <= r_y + DIM_W'(1);
                r_row_base <= r_row_base + ADDR_W'(r_width);
                r_state    <= S_REQ;
              end else begin
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Moore-style strobes decoded from state; load enable is the one Mealy output.
  assign o_rd_req      = (r_state == S_REQ);
  assign o_rd_addr0    = (r_state == S_REQ) ? w_addr0 : '0;
  assign o_rd_addr1    = (r_state == S_REQ) ? w_addr1 : '0;
  assign o_load_enable = (r_state == S_WAIT_MEM) && i_rd_valid && !i_abort;
  assign o_simd_start  = (r_state == S_LOAD);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_err         = r_err;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simd_window_sequencer.sv
// Bench for simd_window_sequencer: plays the memory port and SIMD core with
// random latencies and compares every request against a chunk list computed
// directly from the image geometry.
module tb_simd_window_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_base_addr;
  logic [11:0] i_img_width;
  logic [11:0] i_img_height;
  logic        o_rd_req;
  logic [15:0] o_rd_addr0;
  logic [15:0] o_rd_addr1;
  logic        i_rd_ack;
  logic        i_rd_valid;
  logic        o_load_enable;
  logic        o_simd_start;
  logic        i_simd_done;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_dbg_state;

  int n_vec;
  int n_err;

  // Expected chunks: {addr0[15:0], addr1[15:0], x[11:0], y[11:0]}
  logic [55:0] exp_q[$];

  simd_window_sequencer #(.ADDR_W(16), .DIM_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_base_addr  (i_base_addr),
    .i_img_width  (i_img_width),
    .i_img_height (i_img_height),
    .o_rd_req     (o_rd_req),
    .o_rd_addr0   (o_rd_addr0),
    .o_rd_addr1   (o_rd_addr1),
    .i_rd_ack     (i_rd_ack),
    .i_rd_valid   (i_rd_valid),
    .o_load_enable(o_load_enable),
    .o_simd_start (o_simd_start),
    .i_simd_done  (i_simd_done),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: for each row pair y in [0, H-2], chunks x = 0,4,...
  // while x+4 <= W-1; address = base + y*W + x, wrapped to 16 bits.
  task automatic build_model(input logic [15:0] base, input int w, input int h);
    logic [31:0] t;
    logic [15:0] a0;
    logic [15:0] a1;
    exp_q.delete();
    for (int y = 0; y <= h - 2; y++) begin
      for (int x = 0; x + 4 <= w - 1; x += 4) begin
        t  = 32'(base) + 32'(y * w + x);
        a0 = t[15:0];
        t  = 32'(a0) + 32'(w);
        a1 = t[15:0];
        exp_q.push_back({a0, a1, 12'(x), 12'(y)});
      end
    end
  endtask

  // Drives one frame as memory + core; ack_fix >= 0 fixes the ack latency.
  // abort_chunk >= 0 aborts while that chunk is in COMPUTE.
  task automatic run_frame(input logic [15:0] base, input int w, input int h,
                           input int ack_fix, input bit rnd, input int abort_chunk);
    logic [55:0] cur;
    int n_chunk;
    int wt;
    build_model(base, w, h);
    @(negedge clk);
    i_base_addr  = base;
    i_img_width  = 12'(w);
    i_img_height = 12'(h);
    i_start      = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (rnd) begin
      i_base_addr  = 16'($urandom);
      i_img_width  = 12'($urandom_range(0, 4095));
      i_img_height = 12'($urandom_range(0, 4095));
    end
    n_chunk = 0;
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      // request phase
      wt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
      for (int i = 0; i <= wt; i++) begin
        i_rd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        i_rd_ack   = (i == wt);
        #1;
        check("rd_req", 32'(o_rd_req), 32'd1);
        check("addr0", 32'(o_rd_addr0), 32'(cur[55:40]));
        check("addr1", 32'(o_rd_addr1), 32'(cur[39:24]));
        check("x", 32'(o_x), 32'(cur[23:12]));
        check("y", 32'(o_y), 32'(cur[11:0]));
        check("load_en_req", 32'(o_load_enable), 32'd0);
        @(negedge clk);
      end
      i_rd_ack   = 1'b0;
      i_rd_valid = 1'b0;
      // memory wait phase
      wt = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i <= wt; i++) begin
        i_rd_valid = (i == wt);
        #1;
        check("rd_req_wait", 32'(o_rd_req), 32'd0);
        check("load_en", 32'(o_load_enable), 32'(i == wt));
        @(negedge clk);
      end
      // load phase
      i_rd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("simd_start", 32'(o_simd_start), 32'd1);
      check("load_en_load", 32'(o_load_enable), 32'd0);
      @(negedge clk);
      // compute phase
      if (n_chunk == abort_chunk) begin
        i_rd_valid = 1'b0;
        i_abort    = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        #1;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_req", 32'(o_rd_req), 32'd0);
        @(negedge clk);
        #1;
        check("abort_busy2", 32'(o_busy), 32'd0);
        check("abort_done2", 32'(o_done), 32'd0);
        exp_q.delete();
        return;
      end
      wt = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i <= wt; i++) begin
        i_rd_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        i_simd_done = (i == wt);
        i_start     = rnd && (i == 0) && (wt > 0);
        #1;
        check("simd_start_comp", 32'(o_simd_start), 32'd0);
        check("load_en_comp", 32'(o_load_enable), 32'd0);
        check("busy_comp", 32'(o_busy), 32'd1);
        check("err_busy", 32'(o_err), 32'd0);
        @(negedge clk);
      end
      i_simd_done = 1'b0;
      i_start     = 1'b0;
      i_rd_valid  = 1'b0;
      n_chunk++;
    end
    #1;
    check("done", 32'(o_done), 32'd1);
    check("busy_done", 32'(o_busy), 32'd1);
    @(negedge clk);
    #1;
    check("done_pulse", 32'(o_done), 32'd0);
    check("busy_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic do_err(input int w, input int h);
    @(negedge clk);
    i_base_addr  = 16'h1234;
    i_img_width  = 12'(w);
    i_img_height = 12'(h);
    i_start      = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    check("err_pulse", 32'(o_err), 32'd1);
    check("err_busy0", 32'(o_busy), 32'd0);
    check("err_req0", 32'(o_rd_req), 32'd0);
    @(negedge clk);
    #1;
    check("err_clear", 32'(o_err), 32'd0);
    check("err_busy1", 32'(o_busy), 32'd0);
    check("err_req1", 32'(o_rd_req), 32'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_base_addr  = '0;
    i_img_width  = '0;
    i_img_height = '0;
    i_rd_ack     = 1'b0;
    i_rd_valid   = 1'b0;
    i_simd_done  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_req", 32'(o_rd_req), 32'd0);
    check("rst_addr0", 32'(o_rd_addr0), 32'd0);
    check("rst_addr1", 32'(o_rd_addr1), 32'd0);
    check("rst_load", 32'(o_load_enable), 32'd0);
    check("rst_start", 32'(o_simd_start), 32'd0);
    check("rst_x", 32'(o_x), 32'd0);
    check("rst_y", 32'(o_y), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(16'h0100, 13, 3, 0, 1'b0, -1);
    run_frame(16'h2000, 5, 2, 0, 1'b0, -1);
    do_err(4, 8);
    do_err(5, 1);
    run_frame(16'h0400, 9, 3, 3, 1'b0, -1);
    run_frame(16'h0100, 13, 3, 0, 1'b0, 2);
    run_frame(16'h0100, 13, 3, 0, 1'b0, -1);

    // stray valid while idle
    @(negedge clk);
    i_rd_valid = 1'b1;
    #1;
    check("stray_idle_load", 32'(o_load_enable), 32'd0);
    check("stray_idle_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_rd_valid = 1'b0;
    #1;
    check("stray_idle_busy2", 32'(o_busy), 32'd0);

    run_frame(16'hFFFC, 8, 2, 0, 1'b0, -1);

    for (int f = 0; f < 10; f++) begin
      run_frame(16'($urandom), int'($urandom_range(5, 40)), int'($urandom_range(2, 5)),
                -1, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
